// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame-buffer write arbiter.
//   arb_state_t : arbiter FSM states
//   REQ_*       : requester index assignments
//   idx_w()     : width of an index into N requesters (at least 1 bit)
package fb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int REQ_FILL  = 0;
  localparam int REQ_LINE  = 1;
  localparam int REQ_CLEAR = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: scans req starting at ptr, wrapping modulo N, and
// reports the first set request.
//   req    : request vector
//   ptr    : index given highest priority
//   onehot : one-hot winner (zero when nothing is requested)
//   idx    : winner index
//   any    : at least one request is set
module rr_picker
  import fb_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      int          k;
      logic [IW-1:0] w_k;
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      w_k = IW'(k);
      if (!any && req[w_k]) begin
        any         = 1'b1;
        onehot[w_k] = 1'b1;
        idx         = w_k;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer SRAM write-port arbiter: round-robin burst grants with a
// per-beat ack that honours SRAM back-pressure and a forced release after
// MAX_BURST beats.
//   clk, n_rst            : clock, async active-low reset
//   req/req_last          : per-requester request level and last-beat marker
//   req_addr/req_wdata    : flattened per-requester address/data slices
//   gnt, busy             : registered grant and grant-active flag
//   ack                   : beat accepted this cycle (owner only)
//   mem_wen/addr/wdata    : SRAM write port, mem_ready is its back-pressure
//
// state   | meaning
// IDLE    | no owner; arbitrate among pending requests
// GRANT   | owner holds the port; beats complete on ack
// RELEASE | grant dropped; round-robin pointer moves past the owner
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        mem_wen,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  output logic                        busy
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IW-1:0]      r_owner, r_ptr, w_ptr_nxt;
  logic [BW-1:0]      r_beats, w_beats_inc;

  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_any;
  logic               w_own_req, w_own_last, w_ack_any, w_release, w_in_grant;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req    (req),
    .ptr    (r_ptr),
    .onehot (w_pick_onehot),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_own_req   = req[r_owner];
    w_own_last  = req_last[r_owner];
    w_ack_any   = 1'b0;
    w_release   = 1'b0;
    w_beats_inc = r_beats + BW'(1);
    w_ptr_nxt   = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);
    case (r_state)
      IDLE: if (w_pick_any) w_state_nxt = GRANT;
      GRANT: begin
        w_ack_any = w_own_req & mem_ready;
        // An abandoned request releases without writing; otherwise release
        // on the last beat or when the burst budget is used up.
        w_release = !w_own_req ||
                    (w_ack_any && (w_own_last || (w_beats_inc == BW'(MAX_BURST))));
        if (w_release) w_state_nxt = RELEASE;
      end
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_in_grant = (r_state == GRANT);
  assign gnt        = r_gnt;
  assign busy       = w_in_grant;
  assign ack        = w_ack_any ? r_gnt : '0;
  assign mem_wen    = w_in_grant & w_own_req;
  assign mem_addr   = w_in_grant ? req_addr[int'(r_owner)*ADDR_W +: ADDR_W]   : '0;
  assign mem_wdata  = w_in_grant ? req_wdata[int'(r_owner)*DATA_W +: DATA_W] : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_beats <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_gnt   <= w_pick_onehot;
            r_owner <= w_pick_idx;
            r_beats <= '0;
          end
        end
        GRANT: begin
          if (w_ack_any) r_beats <= w_beats_inc;
          if (w_release) r_gnt   <= '0;
        end
        RELEASE: begin
          r_ptr   <= w_ptr_nxt;
          r_beats <= '0;
        end
        default: r_gnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

  localparam int NR = 3;
  localparam int AW = 16;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic [NR-1:0]     tb_req = '0;
  logic [NR-1:0]     tb_last = '0;
  logic [AW-1:0]     tb_addr [NR];
  logic [DW-1:0]     tb_data [NR];
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic              mem_ready = 1'b1;
  logic [NR-1:0]     gnt, ack;
  logic              mem_wen, busy;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = tb_addr[i];
      req_wdata[i*DW +: DW] = tb_data[i];
    end
  end

  fb_write_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16)) u_dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req       (tb_req),
    .req_last  (tb_last),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .ack       (ack),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int idx, input int b);
    tb_addr[idx] = 16'(idx * 'h1000 + 'h100 + b);
    tb_data[idx] = 8'(idx * 16 + b);
  endtask

  task automatic do_reset();
    n_rst     = 1'b0;
    tb_req    = '0;
    tb_last   = '0;
    mem_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  // Owner idx already granted; run nb acked beats starting at beat index first.
  task automatic burst(input int idx, input int first, input int nb, input bit with_last);
    for (int b = first; b < first + nb; b++) begin
      set_beat(idx, b);
      tb_last[idx] = with_last && (b == first + nb - 1);
      #1;
      chk("ack",   ack,       32'(1 << idx));
      chk("wen",   mem_wen,   1);
      chk("addr",  mem_addr,  32'(idx * 'h1000 + 'h100 + b));
      chk("wdata", mem_wdata, 32'(8'(idx * 16 + b)));
      tick();
    end
    tb_last[idx] = 1'b0;
  endtask

  int order [4] = '{0, 1, 2, 0};

  initial begin
    for (int i = 0; i < NR; i++) begin
      tb_addr[i] = '0;
      tb_data[i] = '0;
    end

    // reset state
    #2;
    chk("rst_gnt",  gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wen",  mem_wen, 0);
    chk("rst_ack",  ack, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_wdata, 0);
    do_reset();

    // single 4-beat burst from requester 0
    tb_req = 3'b001;
    #1;
    chk("t1_pre_gnt", gnt, 0);
    tick();
    chk("t1_gnt",  gnt, 3'b001);
    chk("t1_busy", busy, 1);
    burst(0, 0, 4, 1'b1);
    chk("t1_rel_busy", busy, 0);
    chk("t1_rel_gnt",  gnt, 0);
    tb_req = '0;
    tick();
    chk("t1_idle_busy", busy, 0);

    // all requesting, 2-beat bursts, rotation 0,1,2,0
    do_reset();
    tb_req = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t2_gnt",  gnt, 32'(1 << order[k]));
      chk("t2_busy", busy, 1);
      burst(order[k], 0, 2, 1'b1);
      chk("t2_gap1_gnt", gnt, 0);
      chk("t2_gap1_busy", busy, 0);
      tick();
      chk("t2_gap2_gnt", gnt, 0);
      tick();
    end

    // forced release after 16 beats, then requester 1
    do_reset();
    tb_req = 3'b011;
    tick();
    chk("t3_gnt0", gnt, 3'b001);
    burst(0, 0, 16, 1'b0);
    chk("t3_forced_gnt",  gnt, 0);
    chk("t3_forced_busy", busy, 0);
    tick();
    tick();
    chk("t3_gnt1", gnt, 3'b010);

    // back-pressure stall does not advance the beat count
    do_reset();
    tb_req = 3'b001;
    tick();
    chk("t4_gnt", gnt, 3'b001);
    burst(0, 0, 1, 1'b0);
    mem_ready = 1'b0;
    set_beat(0, 1);
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("t4_stall_ack",  ack, 0);
      chk("t4_stall_wen",  mem_wen, 1);
      chk("t4_stall_addr", mem_addr, 32'('h101));
      chk("t4_stall_data", mem_wdata, 32'(1));
      chk("t4_stall_busy", busy, 1);
      tick();
    end
    mem_ready = 1'b1;
    burst(0, 1, 15, 1'b0);
    chk("t4_rel_gnt",  gnt, 0);
    chk("t4_rel_busy", busy, 0);

    // reset mid-burst, then ptr restarts at 0
    do_reset();
    tb_req = 3'b001;
    tick();
    burst(0, 0, 2, 1'b0);
    set_beat(0, 2);
    #1;
    chk("t5_b3_ack", ack, 3'b001);
    #2;
    n_rst = 1'b0;
    #1;
    chk("t5_rst_gnt",  gnt, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_wen",  mem_wen, 0);
    chk("t5_rst_ack",  ack, 0);
    tb_req = 3'b110;
    repeat (2) tick();
    chk("t5_hold_wen", mem_wen, 0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    chk("t5_gnt1", gnt, 3'b010);
    chk("t5_busy", busy, 1);

    // owner abandons after 2 beats; no write, pointer advances past it
    do_reset();
    tb_req = 3'b001;
    tick();
    burst(0, 0, 2, 1'b0);
    tb_req = 3'b100;
    #1;
    chk("t6_drop_wen", mem_wen, 0);
    chk("t6_drop_ack", ack, 0);
    tick();
    chk("t6_rel_gnt",  gnt, 0);
    chk("t6_rel_busy", busy, 0);
    tb_req = 3'b101;
    tick();
    tick();
    chk("t6_next_gnt", gnt, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
